// File: rtl/and16_pkg.sv
// Shared word type and constants for the and16 bitwise AND unit.
package and16_pkg;
    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t WORD_ZERO = 16'h0000;
    localparam word_t WORD_ONES = 16'hFFFF;
endpackage

// File: rtl/and16_if.sv
// Operand/result bundle for and16; master drives operands, slave returns results.
interface and16_if;
    import and16_pkg::*;

    word_t a;
    word_t b;
    logic  en;
    word_t out;
    word_t out_q;
    logic  out_valid;
    logic  out_zero;

    modport master (
        output a, b, en,
        input  out, out_q, out_valid, out_zero
    );

    modport slave (
        input  a, b, en,
        output out, out_q, out_valid, out_zero
    );
endinterface

// File: rtl/and16_and1_slice.sv
// Single-bit AND from two NAND gates, matching the gate-level primitives.
module and1_slice (
    input  logic a,
    input  logic b,
    output logic y
);
    logic n;

    assign n = ~(a & b);
    assign y = ~(n & n);
endmodule

// File: rtl/and16.sv
// 16-bit structural AND with zero flag and optional capture stage.
// Define AND16_PIPE_EN to build the registered out_q/out_valid stage.
module and16
    import and16_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input logic clk,
    input logic rst_n,
    and16_if.slave bus
);
    word_t res;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        and1_slice u_slice (
            .a (bus.a[i]),
            .b (bus.b[i]),
            .y (res[i])
        );
    end

    assign bus.out      = res;
    assign bus.out_zero = ~|res;

`ifdef AND16_PIPE_EN
    word_t q;
    logic  v;

    // Valid drops on any idle cycle; data holds for late readers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= WORD_ZERO;
            v <= 1'b0;
        end else if (bus.en) begin
            q <= res;
            v <= 1'b1;
        end else begin
            v <= 1'b0;
        end
    end

    assign bus.out_q     = q;
    assign bus.out_valid = v;
`else
    // Ports stay for interface parity; nothing is clocked here.
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst_n;
    assign bus.out_q      = res;
    assign bus.out_valid  = bus.en;
`endif
endmodule

// File: tb/tb_and16.sv
// Self-checking bench for and16 (directed plus random), both build variants.
module tb_and16;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    logic [15:0] mq;
    logic        mv;

    and16_if bus ();

    and16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [15:0] obs,
                         input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_and(input logic [15:0] x,
                                            input logic [15:0] y);
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < 16; i++)
            if (x[i] == 1'b1 && y[i] == 1'b1)
                r = r + (16'h0001 << i);
        return r;
    endfunction

    task automatic check_comb(input string tag,
                              input logic [15:0] ta,
                              input logic [15:0] tb);
        logic [15:0] e;
        e = ref_and(ta, tb);
        check({tag, ".out"}, bus.out, e);
        check({tag, ".zero"}, {15'd0, bus.out_zero},
              {15'd0, e == 16'h0000});
    endtask

    task automatic check_reg(input string tag);
        check({tag, ".q"}, bus.out_q, mq);
        check({tag, ".v"}, {15'd0, bus.out_valid}, {15'd0, mv});
    endtask

    task automatic step(input string tag,
                        input logic [15:0] ta,
                        input logic [15:0] tb,
                        input logic ten);
        @(negedge clk);
        bus.a  = ta;
        bus.b  = tb;
        bus.en = ten;
        #1;
        check_comb(tag, ta, tb);
`ifndef AND16_PIPE_EN
        mq = ref_and(ta, tb);
        mv = ten;
`endif
        check_reg({tag, ".pre"});
        @(posedge clk);
        #1;
`ifdef AND16_PIPE_EN
        if (ten) begin
            mq = ref_and(ta, tb);
            mv = 1'b1;
        end else begin
            mv = 1'b0;
        end
`endif
        check_reg({tag, ".post"});
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst_n  = 1'b0;
        bus.a  = 16'h0000;
        bus.b  = 16'h0000;
        bus.en = 1'b0;
        mq     = 16'h0000;
        mv     = 1'b0;
        #1;
        check_comb("rst", 16'h0000, 16'h0000);
        check_reg("rst");

        // Combinational path must work during reset, before any edge.
        bus.a = 16'h1234;
        bus.b = 16'h9876;
        #1;
        check("rst_comb", bus.out, 16'h1034);

        @(negedge clk);
        rst_n = 1'b1;

        step("z0", 16'h0000, 16'h0000, 1'b0);
        step("z1", 16'h0000, 16'hFFFF, 1'b1);
        step("ones", 16'hFFFF, 16'hFFFF, 1'b1);
        step("disj", 16'hAAAA, 16'h5555, 1'b1);
        step("mix", 16'h3CC3, 16'h0FF0, 1'b1);
        step("cap", 16'h1234, 16'h9876, 1'b1);
        check("cap_lit", bus.out_q, 16'h1034);
        step("hold", 16'hFFFF, 16'hFFFF, 1'b0);

        // Asynchronous reset between edges.
        @(negedge clk);
        bus.a  = 16'h1234;
        bus.b  = 16'h9876;
        bus.en = 1'b1;
        @(posedge clk);
        #1;
`ifdef AND16_PIPE_EN
        mq = 16'h1034;
        mv = 1'b1;
`else
        mq = 16'h1034;
        mv = 1'b1;
`endif
        check_reg("pre_arst");
        #2;
        rst_n = 1'b0;
        #1;
`ifdef AND16_PIPE_EN
        mq = 16'h0000;
        mv = 1'b0;
`endif
        check_reg("arst");
        bus.a = 16'hF0F0;
        bus.b = 16'h3C3C;
        #1;
        check_comb("arst_comb", 16'hF0F0, 16'h3C3C);
        @(posedge clk);
        #1;
`ifndef AND16_PIPE_EN
        mq = 16'h3030;
`endif
        check_reg("arst_edge");
        @(negedge clk);
        rst_n = 1'b1;

        step("post_rst", 16'hBEEF, 16'hF00D, 1'b1);

        for (int i = 0; i < 200; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 10 == 0) rb = ~ra;
            step("rnd", ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
